// File: rtl/cam_config.sv
// cam_config: walks the OV7670 register ROM and turns each entry into one SCCB register write.
// Define CAM_CONFIG_TIMEOUT_EN to add the SCCB watchdog that drives o_err.
module cam_config #(
  parameter int unsigned CLK_F    = 25_000_000,
  parameter int unsigned DELAY_MS = 10,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_start,
  output logic [7:0]  o_sccb_addr,
  output logic [7:0]  o_sccb_data,
  input  logic        i_sccb_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);
  localparam logic [31:0] DELAY_CYCLES = 32'((CLK_F / 1000) * DELAY_MS);

  typedef enum logic [3:0] {
    IDLE, READ, DECODE, ISSUE, START, HOLD, WAIT, DELAY, ADVANCE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d, reg_q, reg_d, val_q, val_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout;

`ifdef CAM_CONFIG_TIMEOUT_EN
  localparam logic [31:0] WD_MAX = 32'(TIMEOUT - 1);
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  // Watchdog restarts from zero whenever the FSM changes state.
  assign timeout = (state_q == ISSUE || state_q == WAIT) && !i_sccb_ready && wd_q >= WD_MAX;
  always_comb begin
    wd_d  = (state_d == state_q) ? wd_q + 32'd1 : '0;
    err_d = (state_q == DONE && i_start) ? 1'b0 : (err_q | timeout);
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign o_err = err_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ:   state_d = DECODE;
      DECODE: begin
        if (i_rom_data == 16'hFFFF) begin
          state_d = DONE;
        end else if (i_rom_data == 16'hFFF0) begin
          state_d = DELAY;
          cnt_d   = DELAY_CYCLES - 32'd1;
        end else begin
          state_d = ISSUE;
          reg_d   = i_rom_data[15:8];
          val_d   = i_rom_data[7:0];
        end
      end
      ISSUE:  state_d = i_sccb_ready ? START : (timeout ? DONE : ISSUE);
      START:  state_d = HOLD;
      HOLD:   state_d = WAIT;
      WAIT:   state_d = i_sccb_ready ? ADVANCE : (timeout ? DONE : WAIT);
      DELAY: begin
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 32'd1;
        state_d = (cnt_q == '0) ? ADVANCE : DELAY;
      end
      // Address 255 is the last slot; the table never wraps.
      ADVANCE: begin
        state_d = (addr_q == 8'hFF) ? DONE : READ;
        addr_d  = (addr_q == 8'hFF) ? addr_q : addr_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_rom_addr   = addr_q;
  assign o_sccb_addr  = reg_q;
  assign o_sccb_data  = val_q;
  assign o_sccb_start = state_q == START;
  assign o_busy       = state_q != IDLE && state_q != DONE;
  assign o_done       = state_q == DONE;
endmodule

// File: tb/tb_cam_config.sv
// tb_cam_config: random-table bench for cam_config with a behavioural ROM and SCCB master.
module tb_cam_config;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic        ready, sccb_start, busy, done, err;
  logic [7:0]  rom_addr, sccb_addr, sccb_data;
  logic [15:0] rom_data;
  logic [15:0] rom [256];
  logic [15:0] log_q [$];
  logic [15:0] exp_q [$];
  int          log_t [$];
  int          n_chk = 0, n_pass = 0, cyc = 0, wide = 0, busy_cnt = 0;
  bit          prev_start = 0, hold_low = 0, never = 0, stuck = 0;

  always #5 clk = ~clk;

  cam_config #(.CLK_F(100_000), .DELAY_MS(1), .TIMEOUT(500)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_sccb_start(sccb_start), .o_sccb_addr(sccb_addr),
    .o_sccb_data(sccb_data), .i_sccb_ready(ready), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master: busy for 20 cycles after each request, or forever when never is set.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_cnt <= 0;
      stuck    <= 0;
    end else if (sccb_start) begin
      busy_cnt <= 20;
      stuck    <= never;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign ready = busy_cnt == 0 && !hold_low && !stuck;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sccb_start) begin
      log_q.push_back({sccb_addr, sccb_data});
      log_t.push_back(cyc + 1);
    end
    if (sccb_start && prev_start) wide <= wide + 1;
    prev_start <= sccb_start;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      step();
      n++;
    end
    chk("done_in_time", done, 1);
  endtask

  task automatic wait_start(input int lim);
    int n = 0;
    while (!sccb_start && n < lim) begin
      step();
      n++;
    end
    chk("start_seen", sccb_start, 1);
  endtask

  task automatic clear_log();
    log_q.delete();
    log_t.delete();
  endtask

  // Expected writes: every entry up to the end marker (or the table end), minus delays.
  task automatic build_exp(output int end_addr);
    exp_q.delete();
    end_addr = 255;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        end_addr = a;
        break;
      end
      if (rom[a] != 16'hFFF0) exp_q.push_back(rom[a]);
    end
  endtask

  task automatic compare_log();
    chk("n_writes", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("write%0d", i), log_q[i], exp_q[i]);
  endtask

  task automatic fill_rand();
    for (int a = 0; a < 256; a++) rom[a] = {8'($urandom_range(0, 254)), 8'($urandom)};
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_rom_addr"}, rom_addr, 0);
    chk({pfx, "_start"}, sccb_start, 0);
    chk({pfx, "_sccb_addr"}, sccb_addr, 0);
    chk({pfx, "_sccb_data"}, sccb_data, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  initial begin
    int t0, end_addr, gap, stall_starts, unstable;
    fill_rand();
    repeat (3) step();
    check_zero("reset");
    rstn = 1'b1;
    step();

    // Basic table with one settle delay.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    build_exp(end_addr);
    clear_log();
    t0 = cyc;
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_start(50);
    chk("first_start_lat", cyc - t0, 4);
    wait_done(2000);
    compare_log();
    gap = log_t.size() >= 2 ? log_t[1] - log_t[0] : 0;
    chk("delay_gap_ge100", gap >= 100, 1);
    chk("basic_done", done, 1);
    chk("basic_busy", busy, 0);
    chk("basic_end_addr", rom_addr, 32'(end_addr));

    // Ready held low while in ISSUE.
    rom[0] = 16'h1234; rom[1] = 16'hFFFF;
    hold_low = 1;
    clear_log();
    pulse_start();
    stall_starts = 0;
    unstable = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (sccb_start) stall_starts++;
      if (i >= 2 && {sccb_addr, sccb_data} != 16'h1234) unstable++;
    end
    chk("stall_no_start", stall_starts, 0);
    hold_low = 0;
    step();
    chk("start_after_ready", sccb_start, 1);
    step();
    chk("start_one_cycle", sccb_start, 0);
    for (int i = 0; i < 200 && !done; i++) begin
      if ({sccb_addr, sccb_data} != 16'h1234) unstable++;
      step();
    end
    chk("addr_data_stable", unstable, 0);
    chk("stall_done", done, 1);

    // Reset in the middle of a delay.
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    clear_log();
    pulse_start();
    wait_start(50);
    repeat (40) step();
    chk("in_delay_busy", busy, 1);
    chk("in_delay_writes", log_q.size(), 1);
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    step();
    rstn = 1'b1;
    step();
    check_zero("post_rst");
    clear_log();
    pulse_start();
    wait_start(50);
    step();
    chk("rst_first_write", log_q.size() > 0 ? log_q[0] : 16'h0, 16'h1280);
    wait_done(2000);

    // Full table with no markers: 256 writes, then stop at address FF.
    fill_rand();
    build_exp(end_addr);
    clear_log();
    pulse_start();
    wait_done(12000);
    compare_log();
    chk("full_end_addr", rom_addr, 8'hFF);
    chk("full_busy", busy, 0);
    clear_log();
    pulse_start();
    chk("restart_done_clr", done, 0);
    chk("restart_addr0", rom_addr, 0);
    chk("restart_busy", busy, 1);
    wait_start(50);
    step();
    chk("restart_first", log_q.size() > 0 ? log_q[0] : 16'h0, rom[0]);

    // SCCB master that never returns ready.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    rom[0] = 16'h1111; rom[1] = 16'hFFFF;
    never = 1;
    pulse_start();
    wait_start(50);
    repeat (400) step();
    chk("wd_early_err", err, 0);
    chk("wd_early_busy", busy, 1);
    repeat (200) step();
`ifdef CAM_CONFIG_TIMEOUT_EN
    chk("wd_err", err, 1);
    chk("wd_done", done, 1);
    chk("wd_busy", busy, 0);
`else
    chk("nowd_err", err, 0);
    chk("nowd_busy", busy, 1);
    chk("nowd_done", done, 0);
`endif
    chk("start_width", wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
